// File: rtl/bool_equiv_sweeper_if.sv
// Purpose : bundles the sweeper's request, vector drive, f/g sample and result signals.
// Latency : none; plain wires between the sweeper and the logic under test.
// Backpres: none; start is a single-cycle request, ignored by the sweeper while busy.
// Ports (master = sweeper side):
//   start          in  request a sweep (IDLE/DONE only)
//   vec            out input vector driven to the logic under test
//   f_in / g_in    in  original / simplified outputs, one bit per channel
//   busy, done     out sweep in progress / results valid
//   equal          out done and no channel mismatched
//   mis_mask       out sticky per-channel mismatch flags
//   first_fail_vec out lowest failing vector, qualified by first_fail_vld
//   err_count      out number of failing vectors
interface bool_equiv_sweeper_if #(
  parameter int N = 3,
  parameter int M = 4
);
  logic         start;
  logic [N-1:0] vec;
  logic [M-1:0] f_in;
  logic [M-1:0] g_in;
  logic         busy;
  logic         done;
  logic         equal;
  logic [M-1:0] mis_mask;
  logic [N-1:0] first_fail_vec;
  logic         first_fail_vld;
  logic [N:0]   err_count;

  modport master (
    input  start, f_in, g_in,
    output vec, busy, done, equal, mis_mask, first_fail_vec, first_fail_vld, err_count
  );

  modport slave (
    output start, f_in, g_in,
    input  vec, busy, done, equal, mis_mask, first_fail_vec, first_fail_vld, err_count
  );
endinterface

// File: rtl/bool_equiv_sweeper.sv
// Purpose : exhaustive equivalence sweep of M f/g channel pairs over all 2^N input vectors.
// Latency : done rises 2^N*SETTLE edges after the start edge; busy high for exactly that long.
// Backpres: start is honoured only in IDLE/DONE; while busy it is dropped, never queued.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset; aborts any sweep and clears all results
//   bus    master side of bool_equiv_sweeper_if (start, vec, f_in/g_in, result outputs)
module bool_equiv_sweeper #(
  parameter int N      = 3,
  parameter int M      = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bool_equiv_sweeper_if.master bus
);

  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  // Counter runs 0..SETTLE-1; the compare happens on the edge where it sits at SETTLE-1,
  // which is the SETTLE-th edge after vec last changed.
  localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE - 1);
  localparam logic [N-1:0]  VEC_MAX  = {N{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [M-1:0]  mis_q, mis_d;
  logic [N-1:0]  ffv_q, ffv_d;
  logic          ffvld_q, ffvld_d;
  logic [N:0]    err_q, err_d;
  logic          equal_q, equal_d;

  logic [M-1:0]  diff;

  // Only consumed on compare edges, so glitches between compares never reach the results.
  assign diff = bus.f_in ^ bus.g_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      mis_q   <= '0;
      ffv_q   <= '0;
      ffvld_q <= 1'b0;
      err_q   <= '0;
      equal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      ffv_q   <= ffv_d;
      ffvld_q <= ffvld_d;
      err_q   <= err_d;
      equal_q <= equal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    ffv_d   = ffv_q;
    ffvld_d = ffvld_q;
    err_d   = err_q;
    equal_d = equal_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // A restart from DONE clears results on the same edge that launches the sweep.
        if (bus.start) begin
          state_d = S_RUN;
          vec_d   = '0;
          cnt_d   = '0;
          mis_d   = '0;
          ffv_d   = '0;
          ffvld_d = 1'b0;
          err_d   = '0;
          equal_d = 1'b0;
        end
      end

      S_RUN: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          mis_d = mis_q | diff;
          if (|diff) begin
            // At most 2^N increments, so N+1 bits never wrap.
            err_d = err_q + (N+1)'(1);
            if (!ffvld_q) begin
              ffv_d   = vec_q;
              ffvld_d = 1'b1;
            end
          end
          if (vec_q == VEC_MAX) begin
            // vec stays at the last vector once the sweep completes.
            state_d = S_DONE;
            equal_d = ~|(mis_q | diff);
          end else begin
            vec_d = vec_q + N'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.vec            = vec_q;
  assign bus.busy           = (state_q == S_RUN);
  assign bus.done           = (state_q == S_DONE);
  assign bus.equal          = equal_q;
  assign bus.mis_mask       = mis_q;
  assign bus.first_fail_vec = ffv_q;
  assign bus.first_fail_vld = ffvld_q;
  assign bus.err_count      = err_q;

endmodule

// File: tb/tb_bool_equiv_sweeper.sv
// Bench for bool_equiv_sweeper: a default-parameter instance wired to the guide expressions
// (with selectable faults) and a minimal N=1/M=1/SETTLE=1 instance.
module tb_bool_equiv_sweeper;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;
  int mode   = 1;  // 1: equivalent, 2: ch2 g=B, 3: ch0 g=0 and ch3 g=1

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bool_equiv_sweeper_if #(.N(3), .M(4)) ifa ();
  bool_equiv_sweeper_if #(.N(1), .M(1)) ifb ();

  bool_equiv_sweeper #(.N(3), .M(4), .SETTLE(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  bool_equiv_sweeper #(.N(1), .M(1), .SETTLE(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  // Logic under test for the 3-input instance. A is the MSB of vec.
  logic a_v, b_v, c_v;
  logic [3:0] f_v, g_v;
  always_comb begin
    a_v = ifa.vec[2];
    b_v = ifa.vec[1];
    c_v = ifa.vec[0];
    f_v[0] = a_v & (~a_v | a_v & b_v);
    g_v[0] = a_v & b_v;
    f_v[1] = b_v & c_v | ~b_v & c_v;
    g_v[1] = c_v;
    f_v[2] = a_v & b_v | a_v & (b_v | c_v) | b_v & (b_v | c_v);
    g_v[2] = a_v & c_v | b_v;
    f_v[3] = (a_v | ~a_v) & (a_v & b_v | a_v & b_v & ~c_v);
    g_v[3] = a_v & b_v;
    if (mode == 2) g_v[2] = b_v;
    if (mode == 3) begin
      g_v[0] = 1'b0;
      g_v[3] = 1'b1;
    end
  end
  assign ifa.f_in = f_v;
  assign ifa.g_in = g_v;

  // 1-input instance: f=A, g=~A differ on both vectors.
  assign ifb.f_in = ifb.vec;
  assign ifb.g_in = ~ifb.vec;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_vec"},  32'(ifa.vec), 32'd0);
    check({tag, "_busy"}, 32'(ifa.busy), 32'd0);
    check({tag, "_done"}, 32'(ifa.done), 32'd0);
    check({tag, "_eq"},   32'(ifa.equal), 32'd0);
    check({tag, "_mask"}, 32'(ifa.mis_mask), 32'd0);
    check({tag, "_ffv"},  32'(ifa.first_fail_vec), 32'd0);
    check({tag, "_vld"},  32'(ifa.first_fail_vld), 32'd0);
    check({tag, "_err"},  32'(ifa.err_count), 32'd0);
  endtask

  // Pulses start, then follows the sweep on negedges. cyc ends as the number of cycles busy
  // was high. inject_at re-asserts start at that sweep cycle to show it is ignored.
  task automatic sweep_a(input string tag, input int inject_at, output int cyc);
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    cyc = 0;
    // First cycle of RUN: previous results must already be gone.
    check({tag, "_clr_done"}, 32'(ifa.done), 32'd0);
    check({tag, "_clr_mask"}, 32'(ifa.mis_mask), 32'd0);
    check({tag, "_clr_err"},  32'(ifa.err_count), 32'd0);
    check({tag, "_clr_vld"},  32'(ifa.first_fail_vld), 32'd0);
    while (ifa.busy === 1'b1 && cyc < 200) begin
      check({tag, "_vec_step"}, 32'(ifa.vec), 32'(cyc / 2));
      ifa.start = (cyc == inject_at);
      @(negedge clk);
      cyc++;
    end
    ifa.start = 1'b0;
    check({tag, "_cycles"}, 32'(cyc), 32'd16);
    check({tag, "_done"},   32'(ifa.done), 32'd1);
    check({tag, "_vec_end"}, 32'(ifa.vec), 32'd7);
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_a("rst");
    check("rst_b_busy", 32'(ifb.busy), 32'd0);
    check("rst_b_err",  32'(ifb.err_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: all channels equivalent.
    mode = 1;
    sweep_a("eq", -1, cyc);
    check("eq_equal", 32'(ifa.equal), 32'd1);
    check("eq_mask",  32'(ifa.mis_mask), 32'd0);
    check("eq_err",   32'(ifa.err_count), 32'd0);
    check("eq_vld",   32'(ifa.first_fail_vld), 32'd0);
    repeat (3) @(negedge clk);
    check("eq_hold_done", 32'(ifa.done), 32'd1);
    check("eq_hold_vec",  32'(ifa.vec), 32'd7);

    // 2: ch2 simplified to B, differs only at ABC=101.
    mode = 2;
    sweep_a("f2", -1, cyc);
    check("f2_mask",  32'(ifa.mis_mask), 32'h4);
    check("f2_ffv",   32'(ifa.first_fail_vec), 32'd5);
    check("f2_vld",   32'(ifa.first_fail_vld), 32'd1);
    check("f2_err",   32'(ifa.err_count), 32'd1);
    check("f2_equal", 32'(ifa.equal), 32'd0);

    // 3: ch0 g=0 fails on 6,7; ch3 g=1 fails on 0..5 -> every vector fails.
    mode = 3;
    sweep_a("f3", -1, cyc);
    check("f3_mask",  32'(ifa.mis_mask), 32'h9);
    check("f3_ffv",   32'(ifa.first_fail_vec), 32'd0);
    check("f3_vld",   32'(ifa.first_fail_vld), 32'd1);
    check("f3_err",   32'(ifa.err_count), 32'd8);
    check("f3_equal", 32'(ifa.equal), 32'd0);

    // 4: start during a sweep is dropped; restart from DONE clears and re-runs.
    mode = 2;
    sweep_a("inj", 5, cyc);
    check("inj_err", 32'(ifa.err_count), 32'd1);
    mode = 1;
    sweep_a("rest", -1, cyc);
    check("rest_equal", 32'(ifa.equal), 32'd1);
    check("rest_err",   32'(ifa.err_count), 32'd0);

    // 5: async reset mid-sweep, once vec=3 (failing vectors already counted).
    mode = 3;
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    cyc = 0;
    while (ifa.vec !== 3'd3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_reach_vec3", 32'(ifa.vec), 32'd3);
    check("mid_err_before", 32'(ifa.err_count), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check_reset_a("mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_no_done", 32'(ifa.done), 32'd0);
    check("mid_idle",    32'(ifa.busy), 32'd0);
    mode = 1;
    sweep_a("post", -1, cyc);
    check("post_equal", 32'(ifa.equal), 32'd1);

    // 6: N=1, M=1, SETTLE=1, f=A, g=~A.
    @(negedge clk);
    ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    cyc = 0;
    while (ifb.busy === 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("n1_cycles", 32'(cyc), 32'd2);
    check("n1_done",   32'(ifb.done), 32'd1);
    check("n1_err",    32'(ifb.err_count), 32'd2);
    check("n1_ffv",    32'(ifb.first_fail_vec), 32'd0);
    check("n1_vld",    32'(ifb.first_fail_vld), 32'd1);
    check("n1_mask",   32'(ifb.mis_mask), 32'd1);
    check("n1_equal",  32'(ifb.equal), 32'd0);
    check("n1_vec",    32'(ifb.vec), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
